fft8_frame_loader: RTL and testbench

- Upstream input stage for the 8-point radix-2 DIT FFT core.
- Collects a serial stream of complex 16-bit samples into 8-sample frames.
- Double-buffers the frames in two ping-pong banks, so one frame fills while the other is presented.
- Presents each completed frame in parallel, together with its FFT/IFFT mode bit, under a valid/ready handshake.

---
 rtl/fft8_frame_loader.sv | 119 +++++++++++
 tb/tb_fft8_frame_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: gathers a serial stream of complex samples into 8-sample
// frames held in two ping-pong banks, and presents each completed frame in
// parallel to the FFT core under a valid/ready handshake.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   s_valid/s_ready    input sample handshake (s_ready combinational)
//   s_re, s_im         signed sample components
//   s_last             last sample of the frame
//   s_mode             0 = FFT, 1 = IFFT; captured on the first sample of a frame
//   m_valid/m_ready    frame handshake (m_valid combinational)
//   m_x                presented frame; [n][0] = real, [n][1] = imag
//   m_mode             mode captured with the presented frame
//   frame_err          registered one-cycle pulse on a mis-framed completion
//   frame_cnt          number of frames handed off, wrapping
module fft8_frame_loader #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_re,
  input  logic signed [DW-1:0] s_im,
  input  logic                 s_last,
  input  logic                 s_mode,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_x [0:N-1][0:1],
  output logic                 m_mode,
  output logic                 frame_err,
  output logic [CW-1:0]        frame_cnt
);

  localparam int unsigned PW = 3;

  logic signed [DW-1:0] bank     [0:1][0:N-1][0:1];
  logic signed [DW-1:0] bank_nxt [0:1][0:N-1][0:1];
  logic [1:0]           full, full_nxt;
  logic [1:0]           mode_b, mode_nxt;
  logic                 wr_bank, rd_bank;
  logic [PW-1:0]        wptr;

  logic s_accept, last_slot, complete, err, handoff;

  // Handshake decode
  assign s_ready   = !full[wr_bank];
  assign m_valid   = full[rd_bank];
  assign s_accept  = s_valid && s_ready;
  assign last_slot = (wptr == PW'(N - 1));
  assign complete  = s_accept && (s_last || last_slot);
  // Early last or missing last: exactly one of the two framing markers is set
  assign err       = s_accept && (s_last != last_slot);
  assign handoff   = m_valid && m_ready;

  // Presented frame always mirrors the read bank
  always_comb begin
    m_x    = bank[rd_bank];
    m_mode = mode_b[rd_bank];
  end

  // Next bank contents: write the accepted sample, zero the tail on early last
  always_comb begin
    bank_nxt = bank;
    mode_nxt = mode_b;
    if (s_accept) begin
      bank_nxt[wr_bank][wptr][0] = s_re;
      bank_nxt[wr_bank][wptr][1] = s_im;
      if (wptr == '0) mode_nxt[wr_bank] = s_mode;
      if (s_last) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (PW'(i) > wptr) begin
            bank_nxt[wr_bank][PW'(i)][0] = '0;
            bank_nxt[wr_bank][PW'(i)][1] = '0;
          end
        end
      end
    end
  end

  // Completion and handoff never target the same bank, so both bits may update
  always_comb begin
    full_nxt = full;
    if (complete) full_nxt[wr_bank] = 1'b1;
    if (handoff)  full_nxt[rd_bank] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank      <= '{default: '0};
      mode_b    <= '0;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wptr      <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      bank      <= bank_nxt;
      mode_b    <= mode_nxt;
      full      <= full_nxt;
      frame_err <= err;
      if (complete) begin
        wr_bank <= ~wr_bank;
        wptr    <= '0;
      end else if (s_accept) begin
        wptr    <= wptr + PW'(1);
      end
      if (handoff) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// tb_fft8_frame_loader: directed self-checking bench for fft8_frame_loader.
// A vector table covers reset and a basic frame; hand-written sequences cover
// backpressure, framing errors, mode capture, simultaneous events and reset.
module tb_fft8_frame_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] s_re = '0;
  logic signed [DW-1:0] s_im = '0;
  logic                 s_last = 1'b0;
  logic                 s_mode = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] m_x [0:N-1][0:1];
  logic                 m_mode;
  logic                 frame_err;
  logic [CW-1:0]        frame_cnt;

  int tests  = 0;
  int failed = 0;

  fft8_frame_loader #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_last    (s_last),
    .s_mode    (s_mode),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_x       (m_x),
    .m_mode    (m_mode),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    int   re;
    int   im;
    logic last;
    logic mode;
    logic mrdy;
    logic e_srdy;
    logic e_mval;
    logic e_err;
    int   e_cnt;
    logic e_mmode;
    int   e_x3re;
    int   e_x3im;
  } vec_t;

  vec_t vt [0:8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0;
    s_re = '0; s_im = '0; m_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Offer one sample and wait (bounded) until it is accepted
  task automatic send(input int re, input int im, input logic last, input logic mode);
    int waited;
    waited = 0;
    s_valid = 1'b1;
    s_re = DW'(re); s_im = DW'(im); s_last = last; s_mode = mode;
    while (!s_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!s_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 50 cycles");
    end else begin
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int base, input logic mode);
    for (int n = 0; n < 8; n++) send(base + n, -(base + n), n == 7, mode);
  endtask

  task automatic pulse_ready();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    // ---------------- Test 1: table-driven basic frame ----------------
    for (int n = 0; n < 8; n++) begin
      vt[n].v = 1'b1; vt[n].re = n + 1; vt[n].im = -(n + 1);
      vt[n].last = (n == 7); vt[n].mode = 1'b0; vt[n].mrdy = 1'b1;
      vt[n].e_srdy = 1'b1; vt[n].e_mval = (n == 7); vt[n].e_err = 1'b0;
      vt[n].e_cnt = 0; vt[n].e_mmode = 1'b0;
      vt[n].e_x3re = (n >= 3) ? 4 : 0;
      vt[n].e_x3im = (n >= 3) ? -4 : 0;
    end
    vt[8].v = 1'b0; vt[8].re = 0; vt[8].im = 0; vt[8].last = 1'b0;
    vt[8].mode = 1'b0; vt[8].mrdy = 1'b1;
    vt[8].e_srdy = 1'b1; vt[8].e_mval = 1'b0; vt[8].e_err = 1'b0;
    vt[8].e_cnt = 1; vt[8].e_mmode = 1'b0; vt[8].e_x3re = 0; vt[8].e_x3im = 0;

    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_x0", m_x[0][0], 0);

    for (int i = 0; i < 9; i++) begin
      s_valid = vt[i].v; s_re = DW'(vt[i].re); s_im = DW'(vt[i].im);
      s_last = vt[i].last; s_mode = vt[i].mode; m_ready = vt[i].mrdy;
      step();
      chk($sformatf("v%0d_s_ready", i), s_ready, vt[i].e_srdy);
      chk($sformatf("v%0d_m_valid", i), m_valid, vt[i].e_mval);
      chk($sformatf("v%0d_err", i), frame_err, vt[i].e_err);
      chk($sformatf("v%0d_cnt", i), frame_cnt, vt[i].e_cnt);
      chk($sformatf("v%0d_m_mode", i), m_mode, vt[i].e_mmode);
      chk($sformatf("v%0d_x3re", i), m_x[3][0], vt[i].e_x3re);
      chk($sformatf("v%0d_x3im", i), m_x[3][1], vt[i].e_x3im);
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;

    // ---------------- Test 2: backpressure with three frames ----------------
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 8; n++) begin
        send(16 * (k + 1) + n, -(16 * (k + 1) + n), n == 7, 1'b0);
        if (!(k == 1 && n == 7)) chk($sformatf("bp_s_ready_%0d_%0d", k, n), s_ready, 1);
      end
    end
    chk("bp_full_s_ready", s_ready, 0);
    chk("bp_full_m_valid", m_valid, 1);
    chk("bp_full_x0", m_x[0][0], 16);
    s_valid = 1'b1; s_re = DW'(48); s_im = DW'(-48); s_last = 1'b0;
    step();
    step();
    chk("bp_stall_s_ready", s_ready, 0);
    chk("bp_stall_x7", m_x[7][0], 23);
    chk("bp_stall_cnt", frame_cnt, 0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("bp_h1_cnt", frame_cnt, 1);
    chk("bp_h1_s_ready", s_ready, 1);
    chk("bp_h1_m_valid", m_valid, 1);
    chk("bp_h1_x0", m_x[0][0], 32);
    step();
    s_valid = 1'b0;
    for (int n = 1; n < 8; n++) send(48 + n, -(48 + n), n == 7, 1'b0);
    chk("bp_f2_x7", m_x[7][1], -39);
    chk("bp_refull_s_ready", s_ready, 0);
    pulse_ready();
    chk("bp_h2_cnt", frame_cnt, 2);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("bp_f3_re%0d", n), m_x[n][0], 48 + n);
      chk($sformatf("bp_f3_im%0d", n), m_x[n][1], -(48 + n));
    end
    pulse_ready();
    chk("bp_h3_cnt", frame_cnt, 3);
    chk("bp_h3_m_valid", m_valid, 0);

    // ---------------- Test 3: early s_last ----------------
    do_reset();
    send_frame(50, 1'b0);
    pulse_ready();
    send_frame(60, 1'b0);
    pulse_ready();
    for (int n = 0; n < 5; n++) begin
      send(100 + n, 100 + n, n == 4, 1'b0);
      if (n < 4) chk($sformatf("early_err_lo%0d", n), frame_err, 0);
    end
    chk("early_err", frame_err, 1);
    chk("early_m_valid", m_valid, 1);
    chk("early_x4", m_x[4][0], 104);
    for (int n = 5; n < 8; n++) begin
      chk($sformatf("early_zero_re%0d", n), m_x[n][0], 0);
      chk($sformatf("early_zero_im%0d", n), m_x[n][1], 0);
    end
    step();
    chk("early_err_drop", frame_err, 0);
    send_frame(120, 1'b0);
    chk("early_next_err", frame_err, 0);
    pulse_ready();
    chk("early_next_x0", m_x[0][0], 120);
    chk("early_next_x7", m_x[7][0], 127);

    // ---------------- Test 4: missing s_last ----------------
    do_reset();
    for (int n = 0; n < 8; n++) send(200 + n, -(200 + n), 1'b0, 1'b0);
    chk("miss_err", frame_err, 1);
    chk("miss_m_valid", m_valid, 1);
    chk("miss_x7", m_x[7][0], 207);
    send(300, -300, 1'b0, 1'b0);
    chk("miss_err_drop", frame_err, 0);
    pulse_ready();
    chk("miss_after_m_valid", m_valid, 0);
    chk("miss_9th_re", m_x[0][0], 300);
    chk("miss_9th_im", m_x[0][1], -300);

    // ---------------- Test 5: mode capture ----------------
    do_reset();
    for (int n = 0; n < 8; n++) send(400 + n, 0, n == 7, n == 0);
    chk("mode_a", m_mode, 1);
    for (int n = 0; n < 8; n++) begin
      send(500 + n, 0, n == 7, n != 0);
      if (n == 3) chk("mode_a_held", m_mode, 1);
    end
    chk("mode_a_final", m_mode, 1);
    pulse_ready();
    chk("mode_b", m_mode, 0);
    chk("mode_b_x0", m_x[0][0], 500);
    chk("mode_cnt", frame_cnt, 1);

    // ---------------- Test 6: completion and handoff on one edge ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_re = DW'(600 + i); s_im = DW'(-(600 + i));
      s_last = (i % 8 == 7); s_mode = 1'b0; m_ready = (i == 15);
      step();
      chk($sformatf("sim_s_ready%0d", i), s_ready, 1);
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    chk("sim_cnt", frame_cnt, 1);
    chk("sim_m_valid", m_valid, 1);
    chk("sim_x0", m_x[0][0], 608);
    pulse_ready();
    chk("sim_cnt2", frame_cnt, 2);
    chk("sim_m_valid2", m_valid, 0);

    // ---------------- Test 7: reset mid-frame ----------------
    do_reset();
    send_frame(700, 1'b1);
    pulse_ready();
    send_frame(710, 1'b1);
    for (int n = 0; n < 5; n++) send(720 + n, 0, 1'b0, 1'b0);
    chk("mr_pre_m_valid", m_valid, 1);
    chk("mr_pre_mode", m_mode, 1);
    chk("mr_pre_cnt", frame_cnt, 1);
    reset = 1'b1;
    #2;
    chk("mr_m_valid", m_valid, 0);
    chk("mr_s_ready", s_ready, 1);
    chk("mr_cnt", frame_cnt, 0);
    chk("mr_mode", m_mode, 0);
    for (int n = 0; n < 8; n++) chk($sformatf("mr_x%0d", n), m_x[n][0], 0);
    step();
    reset = 1'b0;
    step();
    send_frame(800, 1'b0);
    chk("mr_new_m_valid", m_valid, 1);
    chk("mr_new_err", frame_err, 0);
    chk("mr_new_x0", m_x[0][0], 800);
    chk("mr_new_x7", m_x[7][1], -807);
    pulse_ready();
    chk("mr_new_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
